// File: rtl/div_unit.sv
// Iterative RV32M divide unit: DIV/DIVU/REM/REMU over 32 cycles.
// Radix-2 restoring division on operand magnitudes with sign fix-up on exit.
// Divide-by-zero and signed overflow skip the iteration and finish in one cycle.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  div_op,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] div_q, div_d;       // divisor magnitude
  logic [31:0] rem_q, rem_d;       // partial remainder, always < divisor between steps
  logic [31:0] quo_q, quo_d;       // shifts dividend out, quotient bits in
  logic [4:0]  cnt_q, cnt_d;
  logic        q_neg_q, q_neg_d;   // quotient must be negated
  logic        r_neg_q, r_neg_d;   // remainder takes dividend sign
  logic [31:0] result_q, result_d;

  // Operand decode for the request presented in IDLE.
  logic        signed_op;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_zero;
  logic        ovf;

  // Single restoring-division step.
  logic [32:0] r_shift;
  logic [31:0] q_shift;
  logic        r_ge;
  logic [31:0] r_sub;
  logic [31:0] r_next;
  logic [31:0] q_next;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] fin_val;

  // Decode sign flags, magnitudes and the fast-path conditions.
  always_comb begin
    signed_op = ~div_op[0];
    a_neg     = signed_op & operand1[31];
    b_neg     = signed_op & operand2[31];
    a_mag     = a_neg ? (32'd0 - operand1) : operand1;
    b_mag     = b_neg ? (32'd0 - operand2) : operand2;
    div_zero  = (operand2 == 32'd0);
    ovf       = signed_op && (operand1 == 32'h8000_0000) && (operand2 == 32'hFFFF_FFFF);
  end

  // One iteration plus sign correction of the value that will be final after step 31.
  always_comb begin
    r_shift = {1'b0, rem_q[31:0]} << 1;
    r_shift[0] = quo_q[31];
    q_shift = {quo_q[30:0], 1'b0};
    r_ge    = (r_shift >= {1'b0, div_q});
    // The true difference is below 2^32 whenever r_ge holds, so 32 bits suffice.
    r_sub   = r_shift[31:0] - div_q;
    r_next  = r_ge ? r_sub : r_shift[31:0];
    q_next  = {q_shift[31:1], r_ge};
    quo_fix = q_neg_q ? (32'd0 - q_next) : q_next;
    rem_fix = r_neg_q ? (32'd0 - r_next) : r_next;
    fin_val = op_q[1] ? rem_fix : quo_fix;
  end

  // Next-state logic: accept, iterate, finish; flush returns to IDLE with result untouched.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    div_d    = div_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d    = div_op;
          div_d   = b_mag;
          q_neg_d = a_neg ^ b_neg;
          r_neg_d = a_neg;
          rem_d   = 32'd0;
          cnt_d   = 5'd0;
          if (div_zero) begin
            result_d = div_op[1] ? operand1 : 32'hFFFF_FFFF;
            state_d  = StFin;
          end else if (ovf) begin
            result_d = div_op[1] ? 32'd0 : 32'h8000_0000;
            state_d  = StFin;
          end else begin
            quo_d   = a_mag;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          rem_d = r_next;
          quo_d = q_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d = fin_val;
            state_d  = StFin;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= 2'd0;
      div_q    <= 32'd0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      cnt_q    <= 5'd0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      div_q    <= div_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  // Outputs decode from state or come straight from registers.
  always_comb begin
    busy   = (state_q == StCalc);
    done   = (state_q == StFin);
    result = result_q;
  end

endmodule
